// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter between the 6502 data bus and the PPU
//            fetch engine. CPU has priority; a starvation counter forces a
//            PPU slot by pulling CPU RDY low. Optional statistics counters
//            are built when VRAM_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rdy,
    input  logic          ppu_req,
    input  logic [AW-1:0] ppu_addr,
    output logic          ppu_ack,
    output logic          ppu_rvalid,
    output logic [DW-1:0] ppu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_cpu_stall,
    output logic [15:0]   stat_ppu_wait
`endif
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]    r_starve;
    logic [AW-1:0] r_last_addr;
    logic          r_ppu_pend;
    logic          r_cpu_pend;
    logic [DW-1:0] r_ppu_hold;
    logic [DW-1:0] r_cpu_hold;

    logic w_starved;
    logic w_ppu_gnt;
    logic w_cpu_gnt;
    logic w_ppu_rvalid;
    logic w_cpu_rvalid;

    // Grants are suppressed during reset so the RAM sees no access at all.
    assign w_starved = (r_starve == c_STARVE_MAX);
    assign w_ppu_gnt = !rst_pix && ppu_req && (!cpu_req || w_starved);
    assign w_cpu_gnt = !rst_pix && cpu_req && !w_ppu_gnt;

    assign cpu_rdy = !(cpu_req && w_ppu_gnt);
    assign ppu_ack = w_ppu_gnt;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_starve <= 4'd0;
        end else if (!ppu_req || w_ppu_gnt) begin
            r_starve <= 4'd0;
        end else if (w_cpu_gnt && !w_starved) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_comb begin
        mem_addr  = r_last_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        if (w_ppu_gnt) begin
            mem_addr = ppu_addr;
        end else if (w_cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_last_addr <= '0;
        end else if (w_ppu_gnt || w_cpu_gnt) begin
            r_last_addr <= mem_addr;
        end
    end

    // Read returns: a reset cycle kills any return that was in flight.
    assign w_ppu_rvalid = r_ppu_pend && !rst_pix;
    assign w_cpu_rvalid = r_cpu_pend && !rst_pix;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_ppu_pend <= 1'b0;
            r_cpu_pend <= 1'b0;
        end else begin
            r_ppu_pend <= w_ppu_gnt;
            r_cpu_pend <= w_cpu_gnt && !cpu_we;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_ppu_hold <= '0;
            r_cpu_hold <= '0;
        end else begin
            if (w_ppu_rvalid) begin
                r_ppu_hold <= mem_rdata;
            end
            if (w_cpu_rvalid) begin
                r_cpu_hold <= mem_rdata;
            end
        end
    end

    assign ppu_rvalid = w_ppu_rvalid;
    assign ppu_rdata  = w_ppu_rvalid ? mem_rdata : r_ppu_hold;
    assign cpu_rdata  = w_cpu_rvalid ? mem_rdata : r_cpu_hold;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stat_cpu_stall;
    logic [15:0] r_stat_ppu_wait;
    logic        w_cpu_stall;
    logic        w_ppu_wait;

    assign w_cpu_stall = !cpu_rdy;
    assign w_ppu_wait  = ppu_req && !ppu_ack;

    // Both counters saturate; a clear request overrides a same-cycle increment.
    always_ff @(posedge clk_pix) begin
        if (rst_pix || stat_clr) begin
            r_stat_cpu_stall <= 16'd0;
            r_stat_ppu_wait  <= 16'd0;
        end else begin
            if (w_cpu_stall && (r_stat_cpu_stall != 16'hFFFF)) begin
                r_stat_cpu_stall <= r_stat_cpu_stall + 16'd1;
            end
            if (w_ppu_wait && (r_stat_ppu_wait != 16'hFFFF)) begin
                r_stat_ppu_wait <= r_stat_ppu_wait + 16'd1;
            end
        end
    end

    assign stat_cpu_stall = r_stat_cpu_stall;
    assign stat_ppu_wait  = r_stat_ppu_wait;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Self-checking bench for vram_arbiter: directed scenarios plus
//            randomized traffic against a shadow-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int c_STARVE_MAX = 4;

    logic        clk_pix = 1'b0;
    logic        rst_pix = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        ppu_req = 1'b0;
    logic [14:0] ppu_addr = '0;
    logic        ppu_ack;
    logic        ppu_rvalid;
    logic [7:0]  ppu_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_cpu_stall;
    logic [15:0] stat_ppu_wait;
`endif

    vram_arbiter #(.AW(15), .DW(8), .STARVE_MAX(c_STARVE_MAX)) u_dut (
        .clk_pix    (clk_pix),
        .rst_pix    (rst_pix),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rdy    (cpu_rdy),
        .ppu_req    (ppu_req),
        .ppu_addr   (ppu_addr),
        .ppu_ack    (ppu_ack),
        .ppu_rvalid (ppu_rvalid),
        .ppu_rdata  (ppu_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_cpu_stall (stat_cpu_stall),
        .stat_ppu_wait  (stat_ppu_wait)
`endif
    );

    always #5 clk_pix = ~clk_pix;

    // Synchronous single-port RAM, registered read data.
    logic [7:0] ram [0:32767];
    always @(posedge clk_pix) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  shadow [0:32767];
    int          m_wait = 0;
    logic [14:0] m_last_addr = '0;
    logic        m_ppu_pend = 1'b0;
    logic [7:0]  m_ppu_data = '0;
    logic [7:0]  m_ppu_hold = '0;
    logic        m_cpu_pend = 1'b0;
    logic [7:0]  m_cpu_data = '0;
    logic [7:0]  m_cpu_hold = '0;
    int          m_stall = 0;
    int          m_pwait = 0;
    logic        g_clr = 1'b0;
    logic        o_ack = 1'b0;
    logic        o_rdy = 1'b1;
    logic        o_rvalid = 1'b0;

    task automatic run_cycle(input logic rst, input logic c_req, input logic c_we,
                             input logic [14:0] c_addr, input logic [7:0] c_wd,
                             input logic p_req, input logic [14:0] p_addr);
        logic        e_pg, e_cg, e_rdy, e_we;
        logic [14:0] e_addr;
        rst_pix   = rst;
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wd;
        ppu_req   = p_req;
        ppu_addr  = p_addr;
`ifdef VRAM_ARB_STATS_EN
        stat_clr  = g_clr;
`endif
        e_pg   = !rst && p_req && (!c_req || m_wait >= c_STARVE_MAX);
        e_cg   = !rst && c_req && !e_pg;
        e_rdy  = !(c_req && e_pg);
        e_we   = e_cg && c_we;
        e_addr = e_pg ? p_addr : (e_cg ? c_addr : m_last_addr);
        @(negedge clk_pix);
        o_ack    = ppu_ack;
        o_rdy    = cpu_rdy;
        o_rvalid = ppu_rvalid;
        chk("ppu_ack", 32'(ppu_ack), 32'(e_pg));
        chk("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (!rst) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(c_wd));
            chk("ppu_rvalid", 32'(ppu_rvalid), 32'(m_ppu_pend));
            chk("ppu_rdata", 32'(ppu_rdata), 32'(m_ppu_pend ? m_ppu_data : m_ppu_hold));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_pend ? m_cpu_data : m_cpu_hold));
`ifdef VRAM_ARB_STATS_EN
            chk("stat_cpu_stall", 32'(stat_cpu_stall), 32'(m_stall));
            chk("stat_ppu_wait", 32'(stat_ppu_wait), 32'(m_pwait));
`endif
        end else begin
            chk("ppu_rvalid_rst", 32'(ppu_rvalid), 32'd0);
        end
        @(posedge clk_pix);
        #1;
        if (rst) begin
            m_wait = 0; m_last_addr = '0;
            m_ppu_pend = 1'b0; m_cpu_pend = 1'b0;
            m_ppu_hold = '0; m_cpu_hold = '0;
            m_stall = 0; m_pwait = 0;
        end else begin
            if (m_ppu_pend) m_ppu_hold = m_ppu_data;
            if (m_cpu_pend) m_cpu_hold = m_cpu_data;
            m_ppu_pend = e_pg;
            if (e_pg) m_ppu_data = shadow[p_addr];
            m_cpu_pend = e_cg && !c_we;
            if (e_cg && !c_we) m_cpu_data = shadow[c_addr];
            if (e_we) shadow[c_addr] = c_wd;
            if (e_pg || e_cg) m_last_addr = e_addr;
            m_wait = (p_req && !e_pg) ? m_wait + 1 : 0;
            if (g_clr) begin
                m_stall = 0; m_pwait = 0;
            end else begin
                if (!e_rdy && m_stall < 65535) m_stall++;
                if (p_req && !e_pg && m_pwait < 65535) m_pwait++;
            end
        end
    endtask

    task automatic idle();
        run_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h00, 1'b0, 15'h0);
    endtask

    logic        r_c_req, r_c_we, r_p_req, r_rst, stall_prev, acked_prev;
    logic [14:0] r_c_addr, r_p_addr;
    logic [7:0]  r_c_wd;

    initial begin
        @(posedge clk_pix);
        #1;
        run_cycle(1'b1, 1'b0, 1'b0, 15'h0, 8'h00, 1'b0, 15'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 15'h5, 8'hFF, 1'b1, 15'h7);
        idle();
        chk("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("reset_ppu_rdata", 32'(ppu_rdata), 32'd0);

        // Preload the random-traffic window and the PPU test addresses.
        for (int a = 0; a < 64; a++)
            run_cycle(1'b0, 1'b1, 1'b1, 15'(a), 8'($urandom), 1'b0, 15'h0);
        for (int a = 0; a < 4; a++)
            run_cycle(1'b0, 1'b1, 1'b1, 15'h1000 + 15'(a), 8'h10 + 8'(a), 1'b0, 15'h0);

        // CPU only: write then read back.
        run_cycle(1'b0, 1'b1, 1'b1, 15'h0123, 8'hA5, 1'b0, 15'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 15'h0123, 8'h00, 1'b0, 15'h0);
        idle();
        chk("cpu_read_a5", 32'(cpu_rdata), 32'hA5);

        // PPU only, stepping fetch addresses.
        for (int a = 0; a < 4; a++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h00, 1'b1, 15'h1000 + 15'(a));
            chk("ppu_only_ack", 32'(o_ack), 32'd1);
        end
        idle();
        chk("ppu_only_last", 32'(ppu_rdata), 32'h13);

        // Continuous contention: one PPU slot every STARVE_MAX+1 cycles.
        g_clr = 1'b1;
        idle();
        g_clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 15'h0010, 8'h00, 1'b1, 15'h0020);
            chk("contention_ack", 32'(o_ack), 32'((k % 5) == 4));
        end
`ifdef VRAM_ARB_STATS_EN
        chk("stat_stall_20", 32'(stat_cpu_stall), 32'd4);
        chk("stat_wait_20", 32'(stat_ppu_wait), 32'd16);
        g_clr = 1'b1;
        idle();
        g_clr = 1'b0;
        chk("stat_stall_clr", 32'(stat_cpu_stall), 32'd0);
        chk("stat_wait_clr", 32'(stat_ppu_wait), 32'd0);
`endif
        idle();

        // CPU write and PPU fetch of the same address in the same cycle.
        run_cycle(1'b0, 1'b1, 1'b1, 15'h0200, 8'h3C, 1'b1, 15'h0200);
        chk("wr_ppu_n_ack", 32'(o_ack), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h00, 1'b1, 15'h0200);
        chk("wr_ppu_n1_ack", 32'(o_ack), 32'd1);
        idle();
        chk("wr_ppu_data", 32'(ppu_rdata), 32'h3C);

        // Reset while a PPU return is in flight.
        run_cycle(1'b0, 1'b0, 1'b0, 15'h0, 8'h00, 1'b1, 15'h0005);
        run_cycle(1'b1, 1'b1, 1'b0, 15'h0006, 8'h00, 1'b1, 15'h0007);
        chk("rst_cpu_rdy", 32'(o_rdy), 32'd1);
        idle();
        chk("rvalid_after_rst", 32'(o_rvalid), 32'd0);

        // Randomized traffic: CPU repeats a stalled access, PPU holds until ack.
        r_c_req = 0; r_c_we = 0; r_c_addr = '0; r_c_wd = '0;
        r_p_req = 0; r_p_addr = '0; stall_prev = 0; acked_prev = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!stall_prev) begin
                r_c_req  = ($urandom_range(0, 3) != 0);
                r_c_we   = 1'($urandom_range(0, 1));
                r_c_addr = 15'($urandom_range(0, 63));
                r_c_wd   = 8'($urandom);
            end
            if (!r_p_req || acked_prev) begin
                r_p_req  = 1'($urandom_range(0, 1));
                r_p_addr = 15'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                r_p_req = 1'b0;
            end
            r_rst = ($urandom_range(0, 199) == 0);
            g_clr = ($urandom_range(0, 63) == 0);
            run_cycle(r_rst, r_c_req, r_c_we, r_c_addr, r_c_wd, r_p_req, r_p_addr);
            stall_prev = !o_rdy;
            acked_prev = o_ack;
        end
        g_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
